// File: rtl/ifetch_pkg.sv
// Shared types and default sizing for the instruction-fetch front end.
package ifetch_pkg;

    // Operating mode of the fetch unit.
    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    // Default geometry of the instruction memory and fetch start address.
    localparam int DEF_ADDR_W   = 14;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RESET_PC = 0;

    // One fetch-queue entry at the default widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/ifetch_imem.sv
// Simple dual-port instruction RAM: the write port belongs to the programmer
// clock, the read port to the core clock. Registered read and no reset, so it
// maps onto a true dual-clock block RAM.
module ifetch_imem #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              upg_clk_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Programmer write port.
    always_ff @(posedge upg_clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Core read port: data for the address captured at edge E is valid after E.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the instruction memory, lets the UART
// programmer fill it while in LOAD, and in RUN streams sequential words (with
// branch/jump redirect) through a small queue to decode over valid/ready.
module ifetch_unit import ifetch_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              running_o,
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_addr_i,
    input  logic [DATA_W-1:0] upg_data_i,
    input  logic              upg_done_i
);

    localparam int IDX_W = $clog2(FQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Queue entry at this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } slot_t;

    // Programmer side: the memory only accepts writes while the programmer
    // is neither resetting nor reporting completion, which is exactly when
    // the core is (or is about to be) in LOAD.
    logic kickoff;
    logic mem_wen;

    assign kickoff = upg_rst_i | upg_done_i;
    assign mem_wen = upg_wen_i & ~kickoff;

    // Core side state.
    logic              kick_meta_reg;
    logic              kick_s_reg;
    mode_e             mode_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              epoch_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic              inflight_epoch_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    slot_t             fq_mem [FQ_DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic              running;
    logic [PTR_W-1:0]  occ;
    logic [PTR_W:0]    demand;
    logic              pop;
    logic              push;
    logic              issue;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign running = (mode_reg == MODE_RUN);
    assign occ     = wr_ptr_reg - rd_ptr_reg;
    assign wr_idx  = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx  = rd_ptr_reg[IDX_W-1:0];
    assign valid_o = (occ != '0);
    assign pop     = valid_o & ready_i;

    // A response is only kept if it belongs to the current epoch and nothing
    // at this edge (redirect or leaving RUN) is about to flush the queue.
    assign push = running & kick_s_reg & ~redirect_i & inflight_reg
                & (inflight_epoch_reg == epoch_reg);

    // Slots that will be occupied once this edge's pop and the outstanding
    // read land; counting the pop lets a full queue keep streaming at one
    // word per clock even with a two-entry queue.
    assign demand = {1'b0, occ} - (PTR_W+1)'(pop) + (PTR_W+1)'(inflight_reg);
    assign issue  = running & kick_s_reg & ~redirect_i
                  & (demand < (PTR_W+1)'(FQ_DEPTH));

    assign running_o = running;
    assign pc_o      = fq_mem[rd_idx].pc;
    assign instr_o   = fq_mem[rd_idx].instr;

    ifetch_imem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .upg_clk_i (upg_clk_i),
        .wr_en     (mem_wen),
        .wr_addr   (upg_addr_i),
        .wr_data   (upg_data_i),
        .clk       (clk),
        .rd_en     (issue),
        .rd_addr   (pc_reg),
        .rd_data   (rd_data)
    );

    // Two-flop synchroniser bringing the kickoff level into the core clock.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            kick_meta_reg <= 1'b0;
            kick_s_reg    <= 1'b0;
        end else begin
            kick_meta_reg <= kickoff;
            kick_s_reg    <= kick_meta_reg;
        end
    end

    // Mode FSM plus fetch PC, epoch, in-flight tracking and queue pointers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_reg           <= MODE_LOAD;
            pc_reg             <= ADDR_W'(RESET_PC);
            epoch_reg          <= 1'b0;
            inflight_reg       <= 1'b0;
            inflight_pc_reg    <= '0;
            inflight_epoch_reg <= 1'b0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
        end else begin
            case (mode_reg)
                MODE_LOAD: begin
                    inflight_reg <= 1'b0;
                    rd_ptr_reg   <= wr_ptr_reg;
                    if (kick_s_reg) begin
                        mode_reg <= MODE_RUN;
                        pc_reg   <= ADDR_W'(RESET_PC);
                    end
                end
                MODE_RUN: begin
                    if (!kick_s_reg) begin
                        // Back to LOAD: drop everything still in the pipe.
                        mode_reg     <= MODE_LOAD;
                        rd_ptr_reg   <= wr_ptr_reg;
                        epoch_reg    <= ~epoch_reg;
                        inflight_reg <= 1'b0;
                    end else if (redirect_i) begin
                        // Redirect wins over issue and push; a handshake at
                        // this edge is swallowed by the flush after it
                        // completes on the decode side.
                        pc_reg       <= redirect_addr_i;
                        rd_ptr_reg   <= wr_ptr_reg;
                        epoch_reg    <= ~epoch_reg;
                        inflight_reg <= 1'b0;
                    end else begin
                        inflight_reg <= issue;
                        if (issue) begin
                            inflight_pc_reg    <= pc_reg;
                            inflight_epoch_reg <= epoch_reg;
                            pc_reg             <= pc_reg + ADDR_W'(1);
                        end
                        if (push) begin
                            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        end
                        if (pop) begin
                            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Fetch-queue storage: the returning memory word is written with its PC.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_mem[i] <= '0;
            end
        end else if (push) begin
            fq_mem[wr_idx] <= '{pc: inflight_pc_reg, instr: rd_data};
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed timing steps around mode changes and
// redirects, plus randomized ready/redirect traffic checked against an
// instruction-stream model (expected next PC and a shadow of memory).
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int FQ = 4;

    logic          clk = 1'b0;
    logic          upg_clk = 1'b0;
    logic          rst_n;
    logic          redirect_i;
    logic [AW-1:0] redirect_addr_i;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] pc_o;
    logic          valid_o;
    logic          ready_i;
    logic          running_o;
    logic          upg_rst_i;
    logic          upg_wen_i;
    logic [AW-1:0] upg_addr_i;
    logic [DW-1:0] upg_data_i;
    logic          upg_done_i;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_pc;
    int            run_len;
    bit            hold_chk;
    fq_entry_t     held;
    logic [DW-1:0] mem_m [1<<AW];
    logic [DW-1:0] boot [4];

    always #5  clk = ~clk;
    always #20 upg_clk = ~upg_clk;

    ifetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (0),
        .FQ_DEPTH (FQ)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .running_o       (running_o),
        .upg_clk_i       (upg_clk),
        .upg_rst_i       (upg_rst_i),
        .upg_wen_i       (upg_wen_i),
        .upg_addr_i      (upg_addr_i),
        .upg_data_i      (upg_data_i),
        .upg_done_i      (upg_done_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Programmer write on the upg clock; the shadow follows the acceptance rule.
    task automatic upg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge upg_clk);
        upg_wen_i  = 1'b1;
        upg_addr_i = a;
        upg_data_i = d;
        if (!upg_done_i && !upg_rst_i) mem_m[a] = d;
    endtask

    task automatic upg_idle();
        @(negedge upg_clk);
        upg_wen_i = 1'b0;
    endtask

    // One core cycle: drive inputs just after the falling edge, check the
    // outputs that stand now, then advance to the next falling edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [AW-1:0] tgt);
        ready_i         = rdy;
        redirect_i      = redir;
        redirect_addr_i = tgt;
        if (hold_chk) begin
            chk("hold_valid", 64'(valid_o), 64'(1));
            chk("hold_pc", 64'(pc_o), 64'(held.pc));
            chk("hold_instr", 64'(instr_o), 64'(held.instr));
        end
        if (valid_o && rdy) begin
            chk("deliver_pc", 64'(pc_o), 64'(exp_pc));
            chk("deliver_instr", 64'(instr_o), 64'(mem_m[exp_pc]));
            exp_pc = exp_pc + 1'b1;
            run_len++;
        end
        hold_chk   = valid_o && !rdy && !redir;
        held.pc    = pc_o;
        held.instr = instr_o;
        if (redir) begin
            exp_pc  = tgt;
            run_len = 0;
        end
        @(negedge clk);
    endtask

    task automatic wait_running(input string tag, input logic val);
        int n;
        n = 0;
        while (running_o !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(running_o), 64'(val));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        ready_i    = 1'b0;
        redirect_i = 1'b0;
        while (valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(valid_o), 64'(1));
        hold_chk = 1'b0;
    endtask

    // Random ready, occasional redirect into programmed regions; long straight
    // runs are cut short so fetch never wanders into unprogrammed words.
    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic          redir;
            logic [AW-1:0] tgt;
            redir = ($urandom_range(0, 19) == 0) || (run_len >= 24);
            if ($urandom_range(0, 1) == 0) tgt = AW'($urandom_range(0, 'h13F));
            else                           tgt = AW'('h3FC0 + $urandom_range(0, 63));
            cycle($urandom_range(0, 1) == 1, redir, tgt);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        boot[0] = 32'h00000013;
        boot[1] = 32'h00100093;
        boot[2] = 32'h00200113;
        boot[3] = 32'h00300193;
        rst_n = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0; ready_i = 1'b0;
        upg_rst_i = 1'b0; upg_wen_i = 1'b0; upg_addr_i = '0; upg_data_i = '0;
        upg_done_i = 1'b0; hold_chk = 1'b0; exp_pc = '0; run_len = 0;
        held = '0;
        #1 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("reset_valid", 64'(valid_o), 64'(0));
        chk("reset_running", 64'(running_o), 64'(0));
        chk("reset_pc", 64'(pc_o), 64'(0));
        chk("reset_instr", 64'(instr_o), 64'(0));

        // Program low region (boot words first) and the top of memory.
        for (int a = 0; a < 'h180; a++) upg_write(AW'(a), (a < 4) ? boot[a] : $urandom);
        for (int a = 'h3F80; a < 'h4000; a++) upg_write(AW'(a), $urandom);
        upg_idle();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("load_running", 64'(running_o), 64'(0));

        // Kick into RUN with decode stalled; valid_o rises two edges later.
        upg_done_i = 1'b1;
        wait_running("kick_running", 1'b1);
        exp_pc = '0; run_len = 0;
        chk("kick_valid_e", 64'(valid_o), 64'(0));
        @(negedge clk);
        chk("kick_valid_e1", 64'(valid_o), 64'(0));
        @(negedge clk);
        chk("kick_valid_e2", 64'(valid_o), 64'(1));
        chk("kick_pc", 64'(pc_o), 64'(0));
        chk("kick_instr", 64'(instr_o), 64'(32'h00000013));

        // Stall for 8 cycles, then stream 0..3 back to back.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", 64'(valid_o), 64'(1));
            cycle(1'b1, 1'b0, '0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
        chk("full_head_pc", 64'(pc_o), 64'(4));

        // Redirect with a full queue.
        cycle(1'b0, 1'b1, AW'('h100));
        chk("redir_valid_e", 64'(valid_o), 64'(0));
        cycle(1'b0, 1'b0, '0);
        chk("redir_valid_e1", 64'(valid_o), 64'(0));
        cycle(1'b0, 1'b0, '0);
        chk("redir_valid_e2", 64'(valid_o), 64'(1));
        chk("redir_pc", 64'(pc_o), 64'('h100));

        // Redirect to the last word: wraps to 0.
        cycle(1'b1, 1'b1, AW'('h3FFF));
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk("wrap_pc_top", 64'(pc_o), 64'('h3FFF));
        cycle(1'b1, 1'b0, '0);
        chk("wrap_valid", 64'(valid_o), 64'(1));
        chk("wrap_pc_zero", 64'(pc_o), 64'(0));
        cycle(1'b1, 1'b0, '0);

        // Back-to-back redirects: the last target wins.
        cycle(1'b1, 1'b1, AW'('h20));
        cycle(1'b1, 1'b1, AW'('h30));
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

        rand_run(300);

        // Asynchronous reset mid-stream.
        ready_i = 1'b1; redirect_i = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_running", 64'(running_o), 64'(0));
        @(negedge clk); ready_i = 1'b0;
        @(negedge clk); ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; ready_i = 1'b0;
        hold_chk = 1'b0;
        wait_running("restart_running", 1'b1);
        exp_pc = '0; run_len = 0;
        wait_valid("restart_valid");
        chk("restart_pc", 64'(pc_o), 64'(0));
        rand_run(40);

        // Programmer releases: back to LOAD, rewrite word 0, re-kick.
        ready_i = 1'b0; redirect_i = 1'b0;
        upg_done_i = 1'b0; upg_rst_i = 1'b0;
        wait_running("drop_running", 1'b0);
        chk("drop_valid", 64'(valid_o), 64'(0));
        hold_chk = 1'b0;
        upg_write('0, 32'hDEADBEEF);
        upg_idle();
        upg_done_i = 1'b1;
        wait_running("rekick_running", 1'b1);
        exp_pc = '0; run_len = 0;
        wait_valid("rekick_valid");
        chk("rekick_pc", 64'(pc_o), 64'(0));
        chk("rekick_instr", 64'(instr_o), 64'(32'hDEADBEEF));

        // A write while running must not land.
        upg_write('0, 32'h12345678);
        upg_idle();
        cycle(1'b0, 1'b1, '0);
        wait_valid("runwrite_valid");
        chk("runwrite_instr", 64'(instr_o), 64'(32'hDEADBEEF));
        rand_run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
